ctrl_seq: RTL and testbench
===========================

Name: ctrl_seq

Overview:
- Sequential decode/control stage for the 16-bit 5-stage pipeline, sitting between the IF/ID register and the ID/EX register.
- Decodes a 5-bit opcode plus 2-bit mode into a packed control bundle and registers it into EX with stall bubbles and flush squashing.
- Sequences SIIC/RTI exception entry and return with an EPC register.
- Drains the pipeline on HALT or illegal opcode before asserting halted.

Parameters:
- DATA_W, 16: PC and EPC width.
- EXC_VEC, 16'h0002: SIIC handler address.
- DRAIN_CYC, 3: cycles spent in DRAIN so older EX/MEM/WB instructions retire; legal range 1..15.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- id_valid  in  1  ID holds a real instruction.
- id_opcode  in  5  instruction bits [15:11].
- id_mode  in  2  instruction bits [1:0].
- id_pc_next  in  DATA_W  PC+2 of the ID instruction.
- stall  in  1  hazard unit load-use stall.
- ex_flush  in  1  older branch/jump resolved taken in EX.
- id_ready  out  1  ID may advance.
- ex_valid  out  1  ex_ctrl is live.
- ex_ctrl  out  CTRL_W  registered control bundle.
- redirect_valid  out  1  one-cycle PC redirect.
- redirect_pc  out  DATA_W  redirect target.
- id_flush  out  1  kill IF/ID this cycle.
- epc  out  DATA_W  saved return PC.
- in_handler  out  1  inside an SIIC handler.
- halted  out  1  sticky halted.
- err  out  1  sticky error.

Behaviour:
- Reset (rst_n=0 at a clk edge): state RUN; ex_valid=0; ex_ctrl=0; redirect_valid=0; redirect_pc=0; id_flush=0; epc=0; in_handler=0; halted=0; err=0. Reset mid-DRAIN or mid-HALTED returns to RUN.
- id_ready is combinational: state==RUN && !stall.
- Accept condition: accept = id_valid && id_ready && !ex_flush.
- Decode: ctrl_decode is combinational. Don't-care fields encode as 0; no X is ever driven.
  - ADD/SUB/XOR/ANDN select by mode. SUB sets InvA and Cin.
  - Shift ops use ALUOp = {2'b00, mode}.
  - SEQ/SLT/SLE set InvB and Cin.
- EX register update, every edge:
  - If accept and the op is ordinary: ex_valid<=1 and ex_ctrl<=decode.
  - Otherwise (stall, ex_flush, !id_valid, not RUN, or SIIC/RTI/HALT/illegal): ex_valid<=0 and ex_ctrl<=0.
- ex_flush priority: it overrides every ID action. A squashed SIIC/HALT/illegal has no effect, with no err and no epc write.
- SIIC accepted: epc<=id_pc_next; in_handler<=1; redirect_valid=1 with redirect_pc=EXC_VEC for exactly one cycle (registered, visible the cycle after accept); id_flush pulses in the same cycle as redirect_valid.
- SIIC while in_handler=1: treated as illegal.
- RTI (opcode 00011) accepted:
  - in_handler=1: redirect_pc=epc, redirect_valid and id_flush pulse one cycle, in_handler<=0.
  - in_handler=0: NOP, with ex_valid=0.
- HALT (00000) accepted: enter DRAIN with drain counter = DRAIN_CYC-1.
- Illegal opcode accepted: err<=1, then handled as HALT.
- FSM RUN -> DRAIN -> HALTED:
  - DRAIN decrements the counter each cycle regardless of stall, and exits to HALTED when the counter reaches 0.
  - HALTED sets halted<=1 and holds until reset; redirects are never issued there.
- Simultaneous accept and stall is impossible (id_ready covers stall). A redirect pulse always self-clears the following cycle.

Decomposition:
- Package ctrl_pkg holds:
  - Opcode localparams for all 32 codes.
  - ALUOp encodings: 0000 rll through 1110 slbi, plus 1111 pass-A.
  - The control bundle field offsets, packed MSB to LSB: ALUOp[4], ALUSrc[2], RegDst[2], Jump, Branch, MemRead, MemWrite, MemToReg, RegWrite, PcToReg, RegToPc, InvA, InvB, Cin.
  - CTRL_W=19.
  - The FSM state enum {RUN, DRAIN, HALTED}.
- One sub-module: ctrl_decode, purely combinational opcode/mode to bundle plus is_siic, is_rti, is_halt, is_illegal.

Test Plan:
- ADDI (01000), id_valid=1, no stall -> next cycle ex_valid=1, ALUOp=0100, ALUSrc=01, RegDst=00, RegWrite=1, others 0.
- R-type 11011 mode=01 with stall=1 for 2 cycles, then 0 -> id_ready=0 and ex_valid=0 for 2 cycles, then ex_ctrl with ALUOp=0100, InvA=1, Cin=1.
- SIIC with id_pc_next=16'h0040 -> next cycle redirect_valid=1, redirect_pc=16'h0002, id_flush=1, epc=16'h0040, in_handler=1. Later RTI -> redirect_pc=16'h0040, in_handler=0.
- HALT with DRAIN_CYC=3 -> id_ready=0 immediately; halted=1 exactly 3 cycles after the accept edge, and stays 1 despite further id_valid.
- Opcode 00000 or illegal with ex_flush=1 in the same cycle -> no state change, ex_valid=0, err=0. Illegal without flush -> err=1, then halted after DRAIN_CYC.
- rst_n=0 during DRAIN for 1 cycle -> all outputs return to reset values; next ADDI decodes normally.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the decode/control stage: opcodes, ALU operation codes,
// control-bundle layout and the sequencer state encoding.
package ctrl_pkg;

   localparam int unsigned CTRL_W = 19;

   localparam logic [4:0] OP_HALT   = 5'b00000;
   localparam logic [4:0] OP_NOP    = 5'b00001;
   localparam logic [4:0] OP_SIIC   = 5'b00010;
   localparam logic [4:0] OP_RTI    = 5'b00011;
   localparam logic [4:0] OP_J      = 5'b00100;
   localparam logic [4:0] OP_JR     = 5'b00101;
   localparam logic [4:0] OP_JAL    = 5'b00110;
   localparam logic [4:0] OP_JALR   = 5'b00111;
   localparam logic [4:0] OP_ADDI   = 5'b01000;
   localparam logic [4:0] OP_SUBI   = 5'b01001;
   localparam logic [4:0] OP_XORI   = 5'b01010;
   localparam logic [4:0] OP_ANDNI  = 5'b01011;
   localparam logic [4:0] OP_BEQZ   = 5'b01100;
   localparam logic [4:0] OP_BNEZ   = 5'b01101;
   localparam logic [4:0] OP_BLTZ   = 5'b01110;
   localparam logic [4:0] OP_BGEZ   = 5'b01111;
   localparam logic [4:0] OP_ST     = 5'b10000;
   localparam logic [4:0] OP_LD     = 5'b10001;
   localparam logic [4:0] OP_SLBI   = 5'b10010;
   localparam logic [4:0] OP_STU    = 5'b10011;
   localparam logic [4:0] OP_ROLI   = 5'b10100;
   localparam logic [4:0] OP_SLLI   = 5'b10101;
   localparam logic [4:0] OP_RORI   = 5'b10110;
   localparam logic [4:0] OP_SRLI   = 5'b10111;
   localparam logic [4:0] OP_LBI    = 5'b11000;
   localparam logic [4:0] OP_BTR    = 5'b11001;
   localparam logic [4:0] OP_RSHIFT = 5'b11010;
   localparam logic [4:0] OP_RARITH = 5'b11011;
   localparam logic [4:0] OP_SEQ    = 5'b11100;
   localparam logic [4:0] OP_SLT    = 5'b11101;
   localparam logic [4:0] OP_SLE    = 5'b11110;
   // Opcode 11111 has no instruction assigned and decodes as illegal
   localparam logic [4:0] OP_RSVD   = 5'b11111;

   localparam logic [3:0] ALU_RLL   = 4'b0000;
   localparam logic [3:0] ALU_SLL   = 4'b0001;
   localparam logic [3:0] ALU_RRL   = 4'b0010;
   localparam logic [3:0] ALU_SRL   = 4'b0011;
   localparam logic [3:0] ALU_ADD   = 4'b0100;
   localparam logic [3:0] ALU_XOR   = 4'b0101;
   localparam logic [3:0] ALU_ANDN  = 4'b0110;
   localparam logic [3:0] ALU_SEQ   = 4'b0111;
   localparam logic [3:0] ALU_SLT   = 4'b1000;
   localparam logic [3:0] ALU_SLE   = 4'b1001;
   localparam logic [3:0] ALU_SCO   = 4'b1010;
   localparam logic [3:0] ALU_BTR   = 4'b1011;
   localparam logic [3:0] ALU_LBI   = 4'b1100;
   localparam logic [3:0] ALU_RSVD  = 4'b1101;
   localparam logic [3:0] ALU_SLBI  = 4'b1110;
   localparam logic [3:0] ALU_PASSA = 4'b1111;

   localparam logic [1:0] SRC_REG   = 2'b00;
   localparam logic [1:0] SRC_IMM5  = 2'b01;
   localparam logic [1:0] SRC_IMM8  = 2'b10;
   localparam logic [1:0] SRC_IMM11 = 2'b11;

   localparam logic [1:0] DST_I     = 2'b00;
   localparam logic [1:0] DST_R     = 2'b01;
   localparam logic [1:0] DST_RS    = 2'b10;
   localparam logic [1:0] DST_R7    = 2'b11;

   localparam int unsigned B_ALUOP    = 15;
   localparam int unsigned B_ALUSRC   = 13;
   localparam int unsigned B_REGDST   = 11;
   localparam int unsigned B_JUMP     = 10;
   localparam int unsigned B_BRANCH   = 9;
   localparam int unsigned B_MEMREAD  = 8;
   localparam int unsigned B_MEMWRITE = 7;
   localparam int unsigned B_MEMTOREG = 6;
   localparam int unsigned B_REGWRITE = 5;
   localparam int unsigned B_PCTOREG  = 4;
   localparam int unsigned B_REGTOPC  = 3;
   localparam int unsigned B_INVA     = 2;
   localparam int unsigned B_INVB     = 1;
   localparam int unsigned B_CIN      = 0;

   typedef struct packed {
      logic [3:0] alu_op;
      logic [1:0] alu_src;
      logic [1:0] reg_dst;
      logic       jump;
      logic       branch;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       reg_write;
      logic       pc_to_reg;
      logic       reg_to_pc;
      logic       inv_a;
      logic       inv_b;
      logic       cin;
   } ctrl_t;

   typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode/mode decoder producing the packed control bundle and
// the special-instruction flags consumed by the sequencer.
module ctrl_decode
   import ctrl_pkg::*;
(
   input  logic [4:0]        i_opcode,
   input  logic [1:0]        i_mode,
   output logic [CTRL_W-1:0] o_ctrl,
   output logic              o_is_siic,
   output logic              o_is_rti,
   output logic              o_is_halt,
   output logic              o_is_illegal
);

   ctrl_t w_c;

   assign o_ctrl = w_c;

   always_comb begin
      w_c          = '0;
      o_is_siic    = 1'b0;
      o_is_rti     = 1'b0;
      o_is_halt    = 1'b0;
      o_is_illegal = 1'b0;
      case (i_opcode)
         OP_HALT: o_is_halt = 1'b1;
         OP_NOP:  ;
         OP_SIIC: o_is_siic = 1'b1;
         OP_RTI:  o_is_rti  = 1'b1;
         OP_J: begin
            w_c.jump    = 1'b1;
            w_c.alu_src = SRC_IMM11;
         end
         OP_JR: begin
            w_c.jump      = 1'b1;
            w_c.reg_to_pc = 1'b1;
            w_c.alu_src   = SRC_IMM8;
            w_c.alu_op    = ALU_ADD;
         end
         OP_JAL: begin
            w_c.jump      = 1'b1;
            w_c.pc_to_reg = 1'b1;
            w_c.reg_write = 1'b1;
            w_c.reg_dst   = DST_R7;
            w_c.alu_src   = SRC_IMM11;
         end
         OP_JALR: begin
            w_c.jump      = 1'b1;
            w_c.reg_to_pc = 1'b1;
            w_c.pc_to_reg = 1'b1;
            w_c.reg_write = 1'b1;
            w_c.reg_dst   = DST_R7;
            w_c.alu_src   = SRC_IMM8;
            w_c.alu_op    = ALU_ADD;
         end
         OP_ADDI, OP_SUBI, OP_XORI, OP_ANDNI: begin
            w_c.alu_src   = SRC_IMM5;
            w_c.reg_write = 1'b1;
            case (i_opcode[1:0])
               2'b00:   w_c.alu_op = ALU_ADD;
               2'b01: begin
                  w_c.alu_op = ALU_ADD;
                  w_c.inv_a  = 1'b1;
                  w_c.cin    = 1'b1;
               end
               2'b10:   w_c.alu_op = ALU_XOR;
               default: w_c.alu_op = ALU_ANDN;
            endcase
         end
         OP_BEQZ, OP_BNEZ, OP_BLTZ, OP_BGEZ: begin
            w_c.branch  = 1'b1;
            w_c.alu_op  = ALU_PASSA;
            w_c.alu_src = SRC_IMM8;
         end
         OP_ST: begin
            w_c.mem_write = 1'b1;
            w_c.alu_op    = ALU_ADD;
            w_c.alu_src   = SRC_IMM5;
         end
         OP_LD: begin
            w_c.mem_read   = 1'b1;
            w_c.mem_to_reg = 1'b1;
            w_c.reg_write  = 1'b1;
            w_c.alu_op     = ALU_ADD;
            w_c.alu_src    = SRC_IMM5;
         end
         OP_STU: begin
            w_c.mem_write = 1'b1;
            w_c.reg_write = 1'b1;
            w_c.reg_dst   = DST_RS;
            w_c.alu_op    = ALU_ADD;
            w_c.alu_src   = SRC_IMM5;
         end
         OP_SLBI, OP_LBI: begin
            w_c.alu_op    = (i_opcode == OP_SLBI) ? ALU_SLBI : ALU_LBI;
            w_c.alu_src   = SRC_IMM8;
            w_c.reg_dst   = DST_RS;
            w_c.reg_write = 1'b1;
         end
         // Immediate shifts take the shift kind from the opcode; mode bits are immediate data
         OP_ROLI, OP_SLLI, OP_RORI, OP_SRLI: begin
            w_c.alu_op    = {2'b00, i_opcode[1:0]};
            w_c.alu_src   = SRC_IMM5;
            w_c.reg_write = 1'b1;
         end
         OP_BTR: begin
            w_c.alu_op    = ALU_BTR;
            w_c.reg_dst   = DST_R;
            w_c.reg_write = 1'b1;
         end
         OP_RSHIFT: begin
            w_c.alu_op    = {2'b00, i_mode};
            w_c.reg_dst   = DST_R;
            w_c.reg_write = 1'b1;
         end
         OP_RARITH: begin
            w_c.reg_dst   = DST_R;
            w_c.reg_write = 1'b1;
            case (i_mode)
               2'b00:   w_c.alu_op = ALU_ADD;
               2'b01: begin
                  w_c.alu_op = ALU_ADD;
                  w_c.inv_a  = 1'b1;
                  w_c.cin    = 1'b1;
               end
               2'b10:   w_c.alu_op = ALU_XOR;
               default: w_c.alu_op = ALU_ANDN;
            endcase
         end
         OP_SEQ, OP_SLT, OP_SLE: begin
            w_c.alu_op    = (i_opcode == OP_SEQ) ? ALU_SEQ :
                            (i_opcode == OP_SLT) ? ALU_SLT : ALU_SLE;
            w_c.reg_dst   = DST_R;
            w_c.reg_write = 1'b1;
            w_c.inv_b     = 1'b1;
            w_c.cin       = 1'b1;
         end
         default: o_is_illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/ctrl_seq.sv
// Decode/control stage: registers the decoded bundle into EX, sequences SIIC/RTI
// through EPC, and drains the pipeline before halting on HALT or illegal opcode.
module ctrl_seq
   import ctrl_pkg::*;
#(
   parameter int unsigned         DATA_W    = 16,
   parameter logic [DATA_W-1:0]   EXC_VEC   = DATA_W'(16'h0002),
   parameter int unsigned         DRAIN_CYC = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [4:0]        id_opcode,
   input  logic [1:0]        id_mode,
   input  logic [DATA_W-1:0] id_pc_next,
   input  logic              stall,
   input  logic              ex_flush,
   output logic              id_ready,
   output logic              ex_valid,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic              redirect_valid,
   output logic [DATA_W-1:0] redirect_pc,
   output logic              id_flush,
   output logic [DATA_W-1:0] epc,
   output logic              in_handler,
   output logic              halted,
   output logic              err
);

   localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYC - 1);

   state_t            r_state, w_state_nx;
   logic [3:0]        r_cnt, w_cnt_nx;

   logic [CTRL_W-1:0] w_dec_ctrl;
   logic              w_is_siic, w_is_rti, w_is_halt, w_is_illegal;
   logic              w_accept, w_siic_ok, w_rti_ret, w_illegal, w_stop, w_ordinary;

   logic              w_ex_valid_d, w_redir_d, w_in_handler_d, w_err_d, w_halted_d;
   logic [CTRL_W-1:0] w_ex_ctrl_d;
   logic [DATA_W-1:0] w_redir_pc_d, w_epc_d;

   logic              r_ex_valid, r_redir, r_id_flush, r_in_handler, r_halted, r_err;
   logic [CTRL_W-1:0] r_ex_ctrl;
   logic [DATA_W-1:0] r_redir_pc, r_epc;

   ctrl_decode u_dec (
      .i_opcode     (id_opcode),
      .i_mode       (id_mode),
      .o_ctrl       (w_dec_ctrl),
      .o_is_siic    (w_is_siic),
      .o_is_rti     (w_is_rti),
      .o_is_halt    (w_is_halt),
      .o_is_illegal (w_is_illegal)
   );

   // A nested SIIC cannot be honoured with a single EPC, so it is treated as illegal
   assign w_accept   = id_valid && id_ready && !ex_flush;
   assign w_siic_ok  = w_is_siic && !r_in_handler;
   assign w_rti_ret  = w_is_rti && r_in_handler;
   assign w_illegal  = w_is_illegal || (w_is_siic && r_in_handler);
   assign w_stop     = w_is_halt || w_illegal;
   assign w_ordinary = !(w_is_siic || w_is_rti || w_stop);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= RUN;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nx;
         r_cnt   <= w_cnt_nx;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      case (r_state)
         RUN: begin
            if (w_accept && w_stop) begin
               w_state_nx = DRAIN;
               w_cnt_nx   = DRAIN_INIT;
            end
         end
         DRAIN: begin
            if (r_cnt == '0) w_state_nx = HALTED;
            else             w_cnt_nx   = r_cnt - 4'd1;
         end
         default: w_state_nx = HALTED;
      endcase
   end

   always_comb begin
      id_ready       = (r_state == RUN) && !stall;
      w_ex_valid_d   = w_accept && w_ordinary;
      w_ex_ctrl_d    = w_ex_valid_d ? w_dec_ctrl : '0;
      w_redir_d      = w_accept && (w_siic_ok || w_rti_ret);
      w_redir_pc_d   = '0;
      w_epc_d        = r_epc;
      w_in_handler_d = r_in_handler;
      w_err_d        = r_err || (w_accept && w_illegal);
      w_halted_d     = r_halted || (w_state_nx == HALTED);
      if (w_accept && w_siic_ok) begin
         w_redir_pc_d   = EXC_VEC;
         w_epc_d        = id_pc_next;
         w_in_handler_d = 1'b1;
      end else if (w_accept && w_rti_ret) begin
         w_redir_pc_d   = r_epc;
         w_in_handler_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ex_valid   <= 1'b0;
         r_ex_ctrl    <= '0;
         r_redir      <= 1'b0;
         r_redir_pc   <= '0;
         r_id_flush   <= 1'b0;
         r_epc        <= '0;
         r_in_handler <= 1'b0;
         r_halted     <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         r_ex_valid   <= w_ex_valid_d;
         r_ex_ctrl    <= w_ex_ctrl_d;
         r_redir      <= w_redir_d;
         r_redir_pc   <= w_redir_pc_d;
         r_id_flush   <= w_redir_d;
         r_epc        <= w_epc_d;
         r_in_handler <= w_in_handler_d;
         r_halted     <= w_halted_d;
         r_err        <= w_err_d;
      end
   end

   assign ex_valid       = r_ex_valid;
   assign ex_ctrl        = r_ex_ctrl;
   assign redirect_valid = r_redir;
   assign redirect_pc    = r_redir_pc;
   assign id_flush       = r_id_flush;
   assign epc            = r_epc;
   assign in_handler     = r_in_handler;
   assign halted         = r_halted;
   assign err            = r_err;

endmodule

// File: tb/tb_ctrl_seq.sv
// Directed bench for ctrl_seq: table of single-cycle decode vectors plus
// hand-written sequences for exception, halt/drain, illegal and reset cases.
module tb_ctrl_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        id_valid;
   logic [4:0]  id_opcode;
   logic [1:0]  id_mode;
   logic [15:0] id_pc_next;
   logic        stall;
   logic        ex_flush;
   logic        id_ready;
   logic        ex_valid;
   logic [18:0] ex_ctrl;
   logic        redirect_valid;
   logic [15:0] redirect_pc;
   logic        id_flush;
   logic [15:0] epc;
   logic        in_handler;
   logic        halted;
   logic        err;

   int unsigned n_chk  = 0;
   int unsigned n_pass = 0;

   // Bundle layout: ALUOp[4] ALUSrc[2] RegDst[2] then J B MR MW M2R RW P2R R2P IA IB C
   localparam logic [18:0] C_ADDI = {4'b0100, 2'b01, 2'b00, 11'b00000100000};
   localparam logic [18:0] C_SUB  = {4'b0100, 2'b00, 2'b01, 11'b00000100101};
   localparam logic [18:0] C_XOR  = {4'b0101, 2'b00, 2'b01, 11'b00000100000};
   localparam logic [18:0] C_SLL  = {4'b0001, 2'b00, 2'b01, 11'b00000100000};
   localparam logic [18:0] C_LD   = {4'b0100, 2'b01, 2'b00, 11'b00101100000};
   localparam logic [18:0] C_ST   = {4'b0100, 2'b01, 2'b00, 11'b00010000000};
   localparam logic [18:0] C_SLT  = {4'b1000, 2'b00, 2'b01, 11'b00000100011};
   localparam logic [18:0] C_SEQ  = {4'b0111, 2'b00, 2'b01, 11'b00000100011};
   localparam logic [18:0] C_JAL  = {4'b0000, 2'b11, 2'b11, 11'b10000110000};
   localparam logic [18:0] C_BEQZ = {4'b1111, 2'b10, 2'b00, 11'b01000000000};
   localparam logic [18:0] C_ROLI = {4'b0000, 2'b01, 2'b00, 11'b00000100000};

   typedef struct {
      string       name;
      logic        v;
      logic [4:0]  op;
      logic [1:0]  md;
      logic        st;
      logic        fl;
      logic        exp_rdy;
      logic        exp_v;
      logic [18:0] exp_c;
   } vec_t;

   vec_t tbl[$];

   ctrl_seq #(
      .DATA_W    (16),
      .EXC_VEC   (16'h0002),
      .DRAIN_CYC (3)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .id_valid       (id_valid),
      .id_opcode      (id_opcode),
      .id_mode        (id_mode),
      .id_pc_next     (id_pc_next),
      .stall          (stall),
      .ex_flush       (ex_flush),
      .id_ready       (id_ready),
      .ex_valid       (ex_valid),
      .ex_ctrl        (ex_ctrl),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_flush       (id_flush),
      .epc            (epc),
      .in_handler     (in_handler),
      .halted         (halted),
      .err            (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
   endtask

   task automatic add(input string nm, input logic v, input logic [4:0] op, input logic [1:0] md,
                      input logic st, input logic fl, input logic rdy, input logic ev,
                      input logic [18:0] ec);
      vec_t t;
      t.name = nm; t.v = v; t.op = op; t.md = md; t.st = st; t.fl = fl;
      t.exp_rdy = rdy; t.exp_v = ev; t.exp_c = ec;
      tbl.push_back(t);
   endtask

   // Drive at the falling edge, then advance past the next rising edge
   task automatic cyc(input logic v, input logic [4:0] op, input logic [1:0] md,
                      input logic st, input logic fl, input logic [15:0] pc);
      @(negedge clk);
      id_valid = v; id_opcode = op; id_mode = md; stall = st; ex_flush = fl; id_pc_next = pc;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      id_valid = 1'b0; id_opcode = '0; id_mode = '0; stall = 1'b0; ex_flush = 1'b0; id_pc_next = '0;
      @(posedge clk);
      #1;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, " ex_valid"},   32'(ex_valid), 0);
      chk({tag, " ex_ctrl"},    32'(ex_ctrl), 0);
      chk({tag, " redirect"},   32'(redirect_valid), 0);
      chk({tag, " redir_pc"},   32'(redirect_pc), 0);
      chk({tag, " id_flush"},   32'(id_flush), 0);
      chk({tag, " epc"},        32'(epc), 0);
      chk({tag, " in_handler"}, 32'(in_handler), 0);
      chk({tag, " halted"},     32'(halted), 0);
      chk({tag, " err"},        32'(err), 0);
      chk({tag, " id_ready"},   32'(id_ready), 1);
   endtask

   initial begin
      rst_n = 1'b0;
      id_valid = 1'b0; id_opcode = '0; id_mode = '0; stall = 1'b0; ex_flush = 1'b0; id_pc_next = '0;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_vals("reset");
      @(negedge clk);
      rst_n = 1'b1;

      add("addi",       1, 5'b01000, 2'b00, 0, 0, 1, 1, C_ADDI);
      add("sub",        1, 5'b11011, 2'b01, 0, 0, 1, 1, C_SUB);
      add("xor",        1, 5'b11011, 2'b10, 0, 0, 1, 1, C_XOR);
      add("sll",        1, 5'b11010, 2'b01, 0, 0, 1, 1, C_SLL);
      add("ld",         1, 5'b10001, 2'b10, 0, 0, 1, 1, C_LD);
      add("st",         1, 5'b10000, 2'b00, 0, 0, 1, 1, C_ST);
      add("slt",        1, 5'b11101, 2'b00, 0, 0, 1, 1, C_SLT);
      add("seq",        1, 5'b11100, 2'b00, 0, 0, 1, 1, C_SEQ);
      add("jal",        1, 5'b00110, 2'b01, 0, 0, 1, 1, C_JAL);
      add("beqz",       1, 5'b01100, 2'b00, 0, 0, 1, 1, C_BEQZ);
      add("roli",       1, 5'b10100, 2'b11, 0, 0, 1, 1, C_ROLI);
      add("nop",        1, 5'b00001, 2'b00, 0, 0, 1, 1, '0);
      add("no_valid",   0, 5'b01000, 2'b00, 0, 0, 1, 0, '0);
      add("stalled",    1, 5'b01000, 2'b00, 1, 0, 0, 0, '0);
      add("flushed",    1, 5'b01000, 2'b00, 0, 1, 1, 0, '0);
      add("rti_nohdl",  1, 5'b00011, 2'b00, 0, 0, 1, 0, '0);
      add("halt_flush", 1, 5'b00000, 2'b00, 0, 1, 1, 0, '0);
      add("ill_flush",  1, 5'b11111, 2'b00, 0, 1, 1, 0, '0);
      add("siic_flush", 1, 5'b00010, 2'b00, 0, 1, 1, 0, '0);
      add("addi_after", 1, 5'b01000, 2'b00, 0, 0, 1, 1, C_ADDI);

      foreach (tbl[i]) begin
         @(negedge clk);
         id_valid = tbl[i].v; id_opcode = tbl[i].op; id_mode = tbl[i].md;
         stall = tbl[i].st; ex_flush = tbl[i].fl; id_pc_next = 16'h1234;
         #1;
         chk({tbl[i].name, " id_ready"}, 32'(id_ready), 32'(tbl[i].exp_rdy));
         @(posedge clk);
         #1;
         chk({tbl[i].name, " ex_valid"}, 32'(ex_valid), 32'(tbl[i].exp_v));
         chk({tbl[i].name, " ex_ctrl"},  32'(ex_ctrl),  32'(tbl[i].exp_c));
         chk({tbl[i].name, " redirect"}, 32'(redirect_valid), 0);
      end
      chk("squash err",        32'(err), 0);
      chk("squash epc",        32'(epc), 0);
      chk("squash in_handler", 32'(in_handler), 0);
      chk("squash halted",     32'(halted), 0);

      // Two stalled cycles then release
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         id_valid = 1; id_opcode = 5'b11011; id_mode = 2'b01; stall = 1; ex_flush = 0;
         #1;
         chk("stall id_ready", 32'(id_ready), 0);
         @(posedge clk);
         #1;
         chk("stall ex_valid", 32'(ex_valid), 0);
      end
      cyc(1, 5'b11011, 2'b01, 0, 0, 16'h0);
      chk("unstall ex_valid", 32'(ex_valid), 1);
      chk("unstall ex_ctrl",  32'(ex_ctrl), 32'(C_SUB));

      // SIIC entry and RTI return
      cyc(1, 5'b00010, 2'b00, 0, 0, 16'h0040);
      chk("siic redirect",   32'(redirect_valid), 1);
      chk("siic redir_pc",   32'(redirect_pc), 32'h0002);
      chk("siic id_flush",   32'(id_flush), 1);
      chk("siic epc",        32'(epc), 32'h0040);
      chk("siic in_handler", 32'(in_handler), 1);
      chk("siic ex_valid",   32'(ex_valid), 0);
      cyc(0, 5'b00000, 2'b00, 0, 0, 16'h0);
      chk("siic pulse clr",  32'(redirect_valid), 0);
      chk("siic flush clr",  32'(id_flush), 0);
      cyc(1, 5'b01000, 2'b00, 0, 0, 16'h0);
      chk("hdl addi valid",  32'(ex_valid), 1);
      cyc(1, 5'b00011, 2'b00, 0, 0, 16'h0);
      chk("rti redirect",    32'(redirect_valid), 1);
      chk("rti redir_pc",    32'(redirect_pc), 32'h0040);
      chk("rti id_flush",    32'(id_flush), 1);
      chk("rti in_handler",  32'(in_handler), 0);
      chk("rti ex_valid",    32'(ex_valid), 0);
      cyc(0, 5'b00000, 2'b00, 0, 0, 16'h0);
      chk("rti pulse clr",   32'(redirect_valid), 0);

      // Nested SIIC is illegal: err set, EPC kept, no redirect
      cyc(1, 5'b00010, 2'b00, 0, 0, 16'h0040);
      cyc(0, 5'b00000, 2'b00, 0, 0, 16'h0);
      cyc(1, 5'b00010, 2'b00, 0, 0, 16'h0080);
      chk("nest err",      32'(err), 1);
      chk("nest epc",      32'(epc), 32'h0040);
      chk("nest redirect", 32'(redirect_valid), 0);
      chk("nest id_ready", 32'(id_ready), 0);
      do_reset();
      chk("nest rst err",  32'(err), 0);

      // HALT: halted exactly DRAIN_CYC edges after accept, then sticky
      cyc(1, 5'b00000, 2'b00, 0, 0, 16'h0);
      chk("halt id_ready", 32'(id_ready), 0);
      chk("halt ex_valid", 32'(ex_valid), 0);
      chk("halt halted0",  32'(halted), 0);
      for (int k = 1; k <= 5; k++) begin
         cyc(1, 5'b01000, 2'b00, 0, 0, 16'h0);
         chk($sformatf("halt halted%0d", k), 32'(halted), (k >= 3) ? 1 : 0);
         chk($sformatf("halt exv%0d", k), 32'(ex_valid), 0);
         chk($sformatf("halt redir%0d", k), 32'(redirect_valid), 0);
      end
      chk("halt err", 32'(err), 0);

      // Reset during DRAIN
      do_reset();
      cyc(1, 5'b00000, 2'b00, 0, 0, 16'h0);
      @(negedge clk);
      rst_n = 1'b0; id_valid = 1'b0;
      @(posedge clk);
      #1;
      chk_reset_vals("drain_rst");
      @(negedge clk);
      rst_n = 1'b1;
      cyc(1, 5'b01000, 2'b00, 0, 0, 16'h0);
      chk("post_rst ex_valid", 32'(ex_valid), 1);
      chk("post_rst ex_ctrl",  32'(ex_ctrl), 32'(C_ADDI));

      // Illegal opcode: err, then drain to halted
      cyc(1, 5'b11111, 2'b00, 0, 0, 16'h0);
      chk("ill err",      32'(err), 1);
      chk("ill ex_valid", 32'(ex_valid), 0);
      for (int k = 1; k <= 3; k++) begin
         cyc(0, 5'b00000, 2'b00, 0, 0, 16'h0);
         chk($sformatf("ill halted%0d", k), 32'(halted), (k == 3) ? 1 : 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
